// File: rtl/sram_controller.sv
// Wait-state bridge from the MEM stage to a 16-bit asynchronous SRAM.
// Each 32-bit word is split into two half-word accesses; ready low freezes the pipeline.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_data_out,
  output logic               sram_data_oe,
  input  logic [15:0]        sram_data_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_q, wr_d;
  logic               req, last, hi_half;

  assign req       = rd_en | wr_en;
  assign last      = (cnt_q == LAST);
  assign hi_half   = (state_q == HI);
  assign read_data = rdata_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    wr_d          = wr_q;
    rdata_d       = rdata_q;
    ready         = 1'b1;
    sram_addr     = '0;
    sram_data_out = '0;
    sram_data_oe  = 1'b0;
    sram_we_n     = 1'b1;
    sram_oe_n     = 1'b1;
    case (state_q)
      IDLE: begin
        if (req) begin
          ready   = 1'b0;
          word_d  = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
          wdata_d = write_data;
          wr_d    = wr_en;
          cnt_d   = '0;
          state_d = LO;
        end
      end
      LO, HI: begin
        ready     = 1'b0;
        sram_addr = {word_q, hi_half};
        if (wr_q) begin
          sram_data_oe  = 1'b1;
          sram_data_out = hi_half ? wdata_q[31:16] : wdata_q[15:0];
          // The final cycle of each half keeps data and address stable with the strobe released.
          sram_we_n     = last;
        end else begin
          sram_oe_n = 1'b0;
          if (last) begin
            if (hi_half) rdata_d[31:16] = sram_data_in;
            else         rdata_d[15:0]  = sram_data_in;
          end
        end
        if (last) begin
          cnt_d   = '0;
          state_d = hi_half ? DONE : HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: an SRAM device model plus a word-level reference
// that predicts every bus cycle of each access from its position in the stall.
module tb_sram_controller;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdEn, wrEn;
  logic [31:0] address, writeData, readData;
  logic        ready;
  logic [17:0] sramAddr;
  logic [15:0] sramDataOut, sramDataIn;
  logic        sramDataOe, sramWeN, sramOeN;

  logic [15:0] sramMem [0:262143];
  logic [15:0] refMem [int];
  logic [31:0] lastRead;
  int          errors = 0;
  int          checks = 0;

  sram_controller dut (
    .clk(clk), .rst(rst), .rd_en(rdEn), .wr_en(wrEn), .address(address),
    .write_data(writeData), .read_data(readData), .ready(ready),
    .sram_addr(sramAddr), .sram_data_out(sramDataOut), .sram_data_oe(sramDataOe),
    .sram_data_in(sramDataIn), .sram_we_n(sramWeN), .sram_oe_n(sramOeN)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!sramWeN && sramDataOe) sramMem[sramAddr] <= sramDataOut;
  assign sramDataIn = sramMem[sramAddr];

  function automatic logic [15:0] refRead(int a);
    return refMem.exists(a) ? refMem[a] : 16'h0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleBus(input string tag);
    checkOutput({tag, " we_n"}, 32'(sramWeN), 32'd1);
    checkOutput({tag, " oe_n"}, 32'(sramOeN), 32'd1);
    checkOutput({tag, " data_oe"}, 32'(sramDataOe), 32'd0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle ready", 32'(ready), 32'd1);
      checkIdleBus("idle");
      checkOutput("idle read_data", readData, lastRead);
      @(posedge clk); #1;
    end
  endtask

  // Runs one complete access, starting one time unit after a rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input bit dropReq);
    logic [16:0] w;
    logic        isWr;
    int          half, pos, ha;
    rdEn = rd; wrEn = wr; address = addr; writeData = data;
    isWr = wr;
    w    = 17'((addr - 32'd1024) >> 2);
    for (int k = 0; k <= 2*W+1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput("req ready", 32'(ready), 32'd0);
        checkIdleBus("req");
        checkOutput("req read_data", readData, lastRead);
      end else if (k <= 2*W) begin
        half = (k-1) / W;
        pos  = (k-1) % W;
        ha   = {w, half[0]};
        checkOutput("stall ready", 32'(ready), 32'd0);
        checkOutput("sram_addr", 32'(sramAddr), 32'(ha));
        if (isWr) begin
          checkOutput("wr data_oe", 32'(sramDataOe), 32'd1);
          checkOutput("wr data_out", 32'(sramDataOut), half ? 32'(data[31:16]) : 32'(data[15:0]));
          checkOutput("wr we_n", 32'(sramWeN), (pos == W-1) ? 32'd1 : 32'd0);
          checkOutput("wr oe_n", 32'(sramOeN), 32'd1);
        end else begin
          checkOutput("rd oe_n", 32'(sramOeN), 32'd0);
          checkOutput("rd we_n", 32'(sramWeN), 32'd1);
          checkOutput("rd data_oe", 32'(sramDataOe), 32'd0);
        end
      end else begin
        checkOutput("done ready", 32'(ready), 32'd1);
        checkIdleBus("done");
        if (isWr) begin
          refMem[{w, 1'b0}] = data[15:0];
          refMem[{w, 1'b1}] = data[31:16];
        end else begin
          lastRead = {refRead({w, 1'b1}), refRead({w, 1'b0})};
        end
        checkOutput("done read_data", readData, lastRead);
      end
      @(posedge clk); #1;
      if (k < 2*W+1) begin
        address   = $urandom;
        writeData = $urandom;
        if (dropReq) begin rdEn = 1'b0; wrEn = 1'b0; end
      end else begin
        rdEn = 1'b0; wrEn = 1'b0;
      end
    end
  endtask

  initial begin
    logic [16:0] w;
    int          op;
    logic [31:0] a;
    for (int i = 0; i < 262144; i++) sramMem[i] = 16'h0000;
    lastRead = 32'h0;
    rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; address = '0; writeData = '0;
    #2;
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkIdleBus("reset");
    checkOutput("reset sram_addr", 32'(sramAddr), 32'd0);
    checkOutput("reset data_out", 32'(sramDataOut), 32'd0);
    checkOutput("reset read_data", readData, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] write then read at 1024");
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    checkOutput("sram[0]", 32'(sramMem[0]), 32'h0000BEEF);
    checkOutput("sram[1]", 32'(sramMem[1]), 32'h0000DEAD);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
    checkOutput("read 1024", readData, 32'hDEADBEEF);
    idleCycles(3);

    $display("[TB] back-to-back write/read at 1028");
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
    checkOutput("read 1028", readData, 32'h12345678);
    checkOutput("sram[2]", 32'(sramMem[2]), 32'h00005678);
    checkOutput("sram[3]", 32'(sramMem[3]), 32'h00001234);

    $display("[TB] simultaneous rd/wr is a write");
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0);
    checkOutput("prio read_data held", readData, 32'h12345678);
    idleCycles(1);

    $display("[TB] reset during HI of a write");
    rdEn = 1'b0; wrEn = 1'b1; address = 32'd1040; writeData = 32'hCAFEF00D;
    w = 17'((32'd1040 - 32'd1024) >> 2);
    repeat (W+1) @(posedge clk);
    @(negedge clk);
    checkOutput("pre-abort sram_addr", 32'(sramAddr), 32'({w, 1'b1}));
    rst = 1'b1;
    #1;
    checkIdleBus("abort");
    checkOutput("abort sram_addr", 32'(sramAddr), 32'd0);
    checkOutput("abort data_out", 32'(sramDataOut), 32'd0);
    checkOutput("abort read_data", readData, 32'd0);
    checkOutput("abort ready req", 32'(ready), 32'd0);
    wrEn = 1'b0;
    #1;
    checkOutput("abort ready idle", 32'(ready), 32'd1);
    refMem[{w, 1'b0}] = 16'hF00D;
    lastRead = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
    checkOutput("partial word", readData, 32'h0000F00D);

    $display("[TB] quiet bus");
    idleCycles(20);

    $display("[TB] random accesses");
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'd1024 + 4 * $urandom_range(0, 31);
      case (op)
        0: idleCycles(1);
        1: applyStimulus(1'b1, 1'b0, a, $urandom, 1'($urandom_range(0, 1)));
        2: applyStimulus(1'b0, 1'b1, a, $urandom, 1'($urandom_range(0, 1)));
        default: applyStimulus(1'b1, 1'b1, a, $urandom, 1'($urandom_range(0, 1)));
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'd1024 + 4 * i;
      applyStimulus(1'b1, 1'b0, a, 32'h0, 1'b0);
    end
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Wait-state controller between the MEM stage and the external 16-bit asynchronous SRAM. It replaces the single-cycle data memory. It accepts the MEM stage's read/write enables, the ALU-computed address and the store value. Each 32-bit word is serviced as two 16-bit half-word accesses. A ready signal is returned, and the hazard/freeze logic uses it to stall the whole pipeline (freeze = ~ready).

Parameters:
BASE_ADDR, 1024, processor byte address that maps to SRAM word 0
SRAM_AW, 18, SRAM address width (16-bit half-word granularity)
WAIT_CYCLES, 2, cycles spent on each half-word access; must be >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
rd_en  input  1  load request from MEM stage (mem_r_en)
wr_en  input  1  store request from MEM stage (mem_w_en)
address  input  32  byte address from ALU result
write_data  input  32  store data (Rm value)
read_data  output  32  loaded word, valid in DONE and held until the next read completes
ready  output  1  high when no access is pending; low stalls the pipeline
sram_addr  output  SRAM_AW  SRAM half-word address
sram_data_out  output  16  data driven to SRAM on writes
sram_data_oe  output  1  high while the controller drives the SRAM data bus
sram_data_in  input  16  data returned by SRAM
sram_we_n  output  1  SRAM write strobe, active low
sram_oe_n  output  1  SRAM output enable, active low

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async, immediate):
  - State is IDLE and the wait counter is 0.
  - read_data = 0.
  - sram_we_n = 1, sram_oe_n = 1, sram_data_oe = 0, sram_addr = 0, sram_data_out = 0.
  - ready follows the IDLE rule below.
- Address map:
  - word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Low half address = {word, 0}; high half address = {word, 1}.
  - There is no range check; out-of-range addresses wrap modulo the SRAM size.
- Request: req = rd_en | wr_en. If both are high, the request is a write (write priority).
- States and transitions:
  - IDLE:
    - If req: latch address, write_data and operation type; counter = 0; go to LO.
    - Bus outputs are inactive.
  - LO (WAIT_CYCLES cycles):
    - sram_addr = {word, 0}.
    - Write: sram_data_oe = 1, sram_data_out = wdata[15:0]; sram_we_n = 0 on every LO cycle except the last (hold cycle).
    - Read: sram_oe_n = 0; sram_data_in is captured into read_data[15:0] at the edge ending the last LO cycle.
    - The counter increments each cycle; after the last cycle go to HI with counter = 0.
  - HI: identical to LO using {word, 1}, wdata[31:16] and read_data[31:16]. Then go to DONE.
  - DONE: one cycle, bus inactive, then go to IDLE.
- ready is combinational:
  - ready = 0 in IDLE when req = 1, and in LO and HI.
  - ready = 1 in DONE, and in IDLE when req = 0.
  - Stall length is therefore 2*WAIT_CYCLES+1 cycles; ready rises in the cycle after the last HI cycle.
- The pipeline advances on the edge that ends DONE. A request present in the following IDLE cycle is a new access, so back-to-back accesses need no idle gap.
- Input changes during LO, HI or DONE are ignored because the latched values are used. Dropping req mid-access does not abort the access.
- A write never alters read_data.
- Reset mid-access aborts immediately. The half-word already written stays in the SRAM, and no partial read is reported.

Test Plan:
1. Write request, address = 1024, write_data = 0xDEADBEEF, held through the stall -> ready low 5 cycles. sram_addr = 0 with data 0xBEEF and we_n low for 1 cycle. Then sram_addr = 1 with data 0xDEAD and we_n low for 1 cycle. ready high in cycle 6; model SRAM[0..1] = BEEF, DEAD.
2. After test 1, read request, address = 1024 -> sram_oe_n low on addresses 0 and 1. read_data = 0xDEADBEEF when ready rises, and it is held after rd_en drops.
3. Back-to-back: write 0x12345678 at 1028, then read 1028 with no idle gap -> SRAM addresses 2 and 3 written. Read returns 0x12345678. ready is high for exactly one cycle between the two stalls.
4. rd_en = wr_en = 1, address 1032, data 0xA5A5_5A5A -> treated as a write (we_n pulses, oe_n stays high). read_data is unchanged.
5. Assert rst during the HI cycle of a write -> all outputs reset asynchronously in the same cycle and the state returns to IDLE. With req = 0 after reset, ready = 1.
6. No request for 20 cycles -> ready stays 1, sram_we_n and sram_oe_n stay 1, sram_data_oe stays 0.
